rd_engine_sequencer: RTL and testbench

//   Control stage directly upstream of the AXI read master. Latches a host-programmed read job and launches it with
//   a one-cycle start pulse. Repeats the job for a programmed loop count, optionally advancing the source address.

---
 rtl/rd_engine_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rd_engine_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_engine_sequencer.sv
// Sequencer ahead of the AXI read master: latches a host read job, launches it once per loop,
// and reports completion, error, timeout, abort and cycle-count status.
module rd_engine_sequencer #(
  parameter int LOOP_WIDTH = 16,
  parameter int CYC_WIDTH  = 48
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [63:0]           cfg_source_address,
  input  logic [31:0]           cfg_rd_pattern,
  input  logic [31:0]           cfg_rd_number,
  input  logic [31:0]           cfg_rd_init_data,
  input  logic                  cfg_wrap_mode,
  input  logic [3:0]            cfg_wrap_len,
  input  logic                  cfg_addr_incr,
  input  logic [LOOP_WIDTH-1:0] cfg_loop_count,
  input  logic [31:0]           cfg_timeout,
  output logic                  engine_start_pulse,
  output logic [63:0]           source_address,
  output logic [31:0]           rd_pattern,
  output logic [31:0]           rd_number,
  output logic [31:0]           rd_init_data,
  output logic                  wrap_mode,
  output logic [3:0]            wrap_len,
  input  logic                  rd_done_pulse,
  input  logic [1:0]            rd_error,
  input  logic [63:0]           rd_error_info,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status_error,
  output logic [63:0]           status_error_info,
  output logic                  timeout_flag,
  output logic                  abort_flag,
  output logic [LOOP_WIDTH-1:0] loops_done,
  output logic [31:0]           last_run_cycles,
  output logic [CYC_WIDTH-1:0]  total_cycles
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [63:0]           addr_q, addr_d;
  logic [31:0]           pattern_q, pattern_d;
  logic [31:0]           number_q, number_d;
  logic [31:0]           init_data_q, init_data_d;
  logic                  wrap_mode_q, wrap_mode_d;
  logic [3:0]            wrap_len_q, wrap_len_d;
  logic                  addr_incr_q, addr_incr_d;
  logic [LOOP_WIDTH-1:0] loop_limit_q, loop_limit_d;
  logic [31:0]           timeout_q, timeout_d;
  logic [31:0]           run_cnt_q, run_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [1:0]            serr_q, serr_d;
  logic [63:0]           sinfo_q, sinfo_d;
  logic                  tflag_q, tflag_d;
  logic                  aflag_q, aflag_d;
  logic [LOOP_WIDTH-1:0] loops_q, loops_d;
  logic [31:0]           last_run_q, last_run_d;
  logic [CYC_WIDTH-1:0]  total_q, total_d;

  logic [31:0]           run_cnt_inc_s;
  logic [LOOP_WIDTH-1:0] loops_inc_s;
  logic [63:0]           addr_step_s;
  logic [CYC_WIDTH-1:0]  total_inc_s;

  assign run_cnt_inc_s = run_cnt_q + 32'd1;
  assign loops_inc_s   = loops_q + {{(LOOP_WIDTH-1){1'b0}}, 1'b1};
  // Per-loop address advance: bursts * beats << size, kept to 64 bits.
  assign addr_step_s   = ({32'd0, number_q} * ({56'd0, pattern_q[15:8]} + 64'd1)) << pattern_q[2:0];
  assign total_inc_s   = (total_q == {CYC_WIDTH{1'b1}}) ? total_q
                                                        : total_q + {{(CYC_WIDTH-1){1'b0}}, 1'b1};

  // Next-state and status update for the job sequencer.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pattern_d    = pattern_q;
    number_d     = number_q;
    init_data_d  = init_data_q;
    wrap_mode_d  = wrap_mode_q;
    wrap_len_d   = wrap_len_q;
    addr_incr_d  = addr_incr_q;
    loop_limit_d = loop_limit_q;
    timeout_d    = timeout_q;
    run_cnt_d    = run_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    serr_d       = serr_q;
    sinfo_d      = sinfo_q;
    tflag_d      = tflag_q;
    aflag_d      = aflag_q;
    loops_d      = loops_q;
    last_run_d   = last_run_q;
    total_d      = total_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start && (cfg_rd_number != 32'd0)) begin
          addr_d       = cfg_source_address;
          pattern_d    = cfg_rd_pattern;
          number_d     = cfg_rd_number;
          init_data_d  = cfg_rd_init_data;
          wrap_mode_d  = cfg_wrap_mode;
          wrap_len_d   = cfg_wrap_len;
          addr_incr_d  = cfg_addr_incr;
          loop_limit_d = (cfg_loop_count == {LOOP_WIDTH{1'b0}}) ? {{(LOOP_WIDTH-1){1'b0}}, 1'b1}
                                                                 : cfg_loop_count;
          timeout_d    = cfg_timeout;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          serr_d       = 2'b00;
          sinfo_d      = 64'd0;
          tflag_d      = 1'b0;
          aflag_d      = 1'b0;
          loops_d      = {LOOP_WIDTH{1'b0}};
          last_run_d   = 32'd0;
          total_d      = {CYC_WIDTH{1'b0}};
          state_d      = ST_LAUNCH;
        end else if (cfg_start) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        total_d = total_inc_s;
        if (cfg_abort) begin
          aflag_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          run_cnt_d = 32'd0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        total_d   = total_inc_s;
        run_cnt_d = run_cnt_inc_s;
        // Completion outranks abort, which outranks timeout.
        if (rd_done_pulse) begin
          last_run_d = run_cnt_inc_s;
          loops_d    = loops_inc_s;
          serr_d     = serr_q | rd_error;
          if ((rd_error != 2'b00) && (serr_q == 2'b00)) begin
            sinfo_d = rd_error_info;
          end else begin
            sinfo_d = sinfo_q;
          end
          if ((rd_error != 2'b00) || (loops_inc_s == loop_limit_q)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else if (cfg_abort) begin
          aflag_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if ((timeout_q != 32'd0) && (run_cnt_inc_s == timeout_q)) begin
          tflag_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_GAP: begin
        total_d = total_inc_s;
        if (cfg_abort) begin
          aflag_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (addr_incr_q) begin
            addr_d = addr_q + addr_step_s;
          end else begin
            addr_d = addr_q;
          end
          state_d = ST_LAUNCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      addr_q       <= 64'd0;
      pattern_q    <= 32'd0;
      number_q     <= 32'd0;
      init_data_q  <= 32'd0;
      wrap_mode_q  <= 1'b0;
      wrap_len_q   <= 4'd0;
      addr_incr_q  <= 1'b0;
      loop_limit_q <= {LOOP_WIDTH{1'b0}};
      timeout_q    <= 32'd0;
      run_cnt_q    <= 32'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      serr_q       <= 2'b00;
      sinfo_q      <= 64'd0;
      tflag_q      <= 1'b0;
      aflag_q      <= 1'b0;
      loops_q      <= {LOOP_WIDTH{1'b0}};
      last_run_q   <= 32'd0;
      total_q      <= {CYC_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pattern_q    <= pattern_d;
      number_q     <= number_d;
      init_data_q  <= init_data_d;
      wrap_mode_q  <= wrap_mode_d;
      wrap_len_q   <= wrap_len_d;
      addr_incr_q  <= addr_incr_d;
      loop_limit_q <= loop_limit_d;
      timeout_q    <= timeout_d;
      run_cnt_q    <= run_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      serr_q       <= serr_d;
      sinfo_q      <= sinfo_d;
      tflag_q      <= tflag_d;
      aflag_q      <= aflag_d;
      loops_q      <= loops_d;
      last_run_q   <= last_run_d;
      total_q      <= total_d;
    end
  end

  assign engine_start_pulse = (state_q == ST_LAUNCH);
  assign source_address     = addr_q;
  assign rd_pattern         = pattern_q;
  assign rd_number          = number_q;
  assign rd_init_data       = init_data_q;
  assign wrap_mode          = wrap_mode_q;
  assign wrap_len           = wrap_len_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign status_error       = serr_q;
  assign status_error_info  = sinfo_q;
  assign timeout_flag       = tflag_q;
  assign abort_flag         = aflag_q;
  assign loops_done         = loops_q;
  assign last_run_cycles    = last_run_q;
  assign total_cycles       = total_q;

endmodule

// File: tb/tb_rd_engine_sequencer.sv
// Bench for rd_engine_sequencer: directed vector table, hand sequences for abort/reset corners,
// and random jobs checked against a loop-level reference model.
module tb_rd_engine_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [63:0] cfg_source_address = 64'd0;
  logic [31:0] cfg_rd_pattern = 32'd0, cfg_rd_number = 32'd0, cfg_rd_init_data = 32'd0;
  logic        cfg_wrap_mode = 1'b0;
  logic [3:0]  cfg_wrap_len = 4'd0;
  logic        cfg_addr_incr = 1'b0;
  logic [15:0] cfg_loop_count = 16'd0;
  logic [31:0] cfg_timeout = 32'd0;
  logic        engine_start_pulse;
  logic [63:0] source_address;
  logic [31:0] rd_pattern, rd_number, rd_init_data;
  logic        wrap_mode;
  logic [3:0]  wrap_len;
  logic        rd_done_pulse = 1'b0;
  logic [1:0]  rd_error = 2'b00;
  logic [63:0] rd_error_info = 64'd0;
  logic        busy, done;
  logic [1:0]  status_error;
  logic [63:0] status_error_info;
  logic        timeout_flag, abort_flag;
  logic [15:0] loops_done;
  logic [31:0] last_run_cycles;
  logic [47:0] total_cycles;

  rd_engine_sequencer #(.LOOP_WIDTH(16), .CYC_WIDTH(48)) dut (
    .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_source_address(cfg_source_address), .cfg_rd_pattern(cfg_rd_pattern),
    .cfg_rd_number(cfg_rd_number), .cfg_rd_init_data(cfg_rd_init_data),
    .cfg_wrap_mode(cfg_wrap_mode), .cfg_wrap_len(cfg_wrap_len), .cfg_addr_incr(cfg_addr_incr),
    .cfg_loop_count(cfg_loop_count), .cfg_timeout(cfg_timeout),
    .engine_start_pulse(engine_start_pulse), .source_address(source_address),
    .rd_pattern(rd_pattern), .rd_number(rd_number), .rd_init_data(rd_init_data),
    .wrap_mode(wrap_mode), .wrap_len(wrap_len), .rd_done_pulse(rd_done_pulse),
    .rd_error(rd_error), .rd_error_info(rd_error_info), .busy(busy), .done(done),
    .status_error(status_error), .status_error_info(status_error_info),
    .timeout_flag(timeout_flag), .abort_flag(abort_flag), .loops_done(loops_done),
    .last_run_cycles(last_run_cycles), .total_cycles(total_cycles)
  );

  always #5 clk = ~clk;

  int pulse_cnt = 0;
  always @(negedge clk) if (engine_start_pulse) pulse_cnt++;

  int n_err = 0, n_checks = 0;
  int dly_a[16];
  logic [1:0]  err_a[16];
  logic [63:0] info_a[16];
  logic [63:0] pulse_addr[16];
  logic [63:0] exp_addr[16];
  int n_pulses, first_lat;

  typedef struct {
    logic [31:0] num; logic [7:0] len; logic [2:0] size; logic [15:0] loops; logic incr;
    logic [63:0] addr; logic [31:0] tmo; int d; int eloop; logic [1:0] eval; logic [63:0] einfo;
    int x_pulses; logic [63:0] x_step; logic [15:0] x_loops; logic [31:0] x_last;
    logic [1:0] x_serr; logic [63:0] x_sinfo; logic x_tflag; logic [47:0] x_total; logic [63:0] x_final;
  } vec_t;

  typedef struct {
    int pulses; logic [15:0] loops; logic [31:0] last; logic [1:0] serr; logic [63:0] sinfo;
    logic tflag; logic [47:0] total; logic [63:0] final_addr;
  } exp_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [7:0] len, input logic [2:0] size);
    return {11'd0, 5'd3, len, 5'd0, size};
  endfunction

  task automatic setup_cfg(input logic [31:0] num, input logic [7:0] len, input logic [2:0] size,
                           input logic [15:0] loops, input logic incr, input logic [63:0] addr,
                           input logic [31:0] tmo);
    cfg_source_address = addr;  cfg_rd_pattern = pat(len, size);
    cfg_rd_number = num;        cfg_rd_init_data = 32'hC0DE_0000 ^ num;
    cfg_wrap_mode = 1'b1;       cfg_wrap_len = 4'd5;
    cfg_addr_incr = incr;       cfg_loop_count = loops;  cfg_timeout = tmo;
  endtask

  // Behaves as the read master: answers each start pulse after dly_a[k] cycles.
  task automatic run_job(input logic [31:0] num, input logic [7:0] len, input logic [2:0] size,
                         input logic [15:0] loops, input logic incr, input logic [63:0] addr,
                         input logic [31:0] tmo);
    int waitc;
    setup_cfg(num, len, size, loops, incr, addr, tmo);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    n_pulses = 0; first_lat = -1; waitc = 0;
    while (n_pulses < 16) begin
      if (engine_start_pulse) begin
        if (n_pulses == 0) first_lat = waitc;
        pulse_addr[n_pulses] = source_address;
        repeat (dly_a[n_pulses]) tick();
        rd_done_pulse = 1'b1; rd_error = err_a[n_pulses]; rd_error_info = info_a[n_pulses];
        tick();
        rd_done_pulse = 1'b0; rd_error = 2'b00; rd_error_info = 64'd0;
        n_pulses++; waitc = 0;
      end else if (!busy) begin
        break;
      end else if (waitc > 4) begin
        n_checks++; n_err++;
        $display("FAIL pulse_wait: no start pulse within 4 cycles while busy");
        break;
      end else begin
        tick(); waitc++;
      end
    end
  endtask

  // Loop-level reference: addresses, completions and cycle totals from the job rules.
  function automatic exp_t model(input logic [31:0] num, input logic [7:0] len, input logic [2:0] size,
                                 input logic [15:0] loops, input logic incr, input logic [63:0] addr,
                                 input logic [31:0] tmo);
    exp_t m;
    int eff;
    logic [63:0] step;
    eff  = (loops == 16'd0) ? 1 : int'(loops);
    step = (64'(num) * (64'(len) + 64'd1)) << size;
    m.pulses = 0; m.loops = 16'd0; m.last = 32'd0; m.serr = 2'b00; m.sinfo = 64'd0;
    m.tflag = 1'b0; m.total = 48'd0; m.final_addr = addr;
    for (int k = 0; k < eff; k++) begin
      exp_addr[k] = incr ? addr + step * 64'(k) : addr;
      m.final_addr = exp_addr[k];
      m.pulses++;
      if (k > 0) m.total += 48'd1;
      if ((tmo != 32'd0) && (dly_a[k] > int'(tmo))) begin
        m.total += 48'(tmo) + 48'd1;
        m.tflag = 1'b1;
        break;
      end
      m.total += 48'(dly_a[k] + 1);
      m.loops += 16'd1;
      m.last = 32'(dly_a[k]);
      if (err_a[k] != 2'b00) begin
        m.serr = err_a[k]; m.sinfo = info_a[k];
        break;
      end
    end
    return m;
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    exp_t m;
    logic [31:0] r_num; logic [7:0] r_len; logic [2:0] r_size; logic [15:0] r_loops;
    logic r_incr; logic [63:0] r_addr; logic [31:0] r_tmo;

    tbl[0] = '{32'd4, 8'd7, 3'd0, 16'd1, 1'b0, 64'h8000, 32'd0, 20, 0, 2'b00, 64'h0,
               1, 64'h0, 16'd1, 32'd20, 2'b00, 64'h0, 1'b0, 48'd21, 64'h8000};
    tbl[1] = '{32'd2, 8'd3, 3'd6, 16'd3, 1'b1, 64'h1000, 32'd0, 5, 0, 2'b00, 64'h0,
               3, 64'h200, 16'd3, 32'd5, 2'b00, 64'h0, 1'b0, 48'd20, 64'h1400};
    tbl[2] = '{32'd1, 8'd0, 3'd0, 16'd5, 1'b0, 64'h2000, 32'd0, 4, 2, 2'b01, 64'hDEAD,
               2, 64'h0, 16'd2, 32'd4, 2'b01, 64'hDEAD, 1'b0, 48'd11, 64'h2000};
    tbl[3] = '{32'd1, 8'd0, 3'd0, 16'd1, 1'b0, 64'h3000, 32'd50, 60, 0, 2'b00, 64'h0,
               1, 64'h0, 16'd0, 32'd0, 2'b00, 64'h0, 1'b1, 48'd51, 64'h3000};
    tbl[4] = '{32'd0, 8'd0, 3'd0, 16'd1, 1'b0, 64'h4000, 32'd0, 5, 0, 2'b00, 64'h0,
               0, 64'h0, 16'd0, 32'd0, 2'b00, 64'h0, 1'b1, 48'd51, 64'h3000};
    tbl[5] = '{32'd1, 8'd0, 3'd0, 16'd0, 1'b0, 64'h5000, 32'd0, 3, 0, 2'b00, 64'h0,
               1, 64'h0, 16'd1, 32'd3, 2'b00, 64'h0, 1'b0, 48'd4, 64'h5000};
    tbl[6] = '{32'd16, 8'd0, 3'd0, 16'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 32'd7, 7, 0, 2'b00, 64'h0,
               2, 64'd16, 16'd2, 32'd7, 2'b00, 64'h0, 1'b0, 48'd17, 64'h8};
    tbl[7] = '{32'd1, 8'd0, 3'd0, 16'd2, 1'b0, 64'h6000, 32'd0, 2, 2, 2'b10, 64'hBEEF,
               2, 64'h0, 16'd2, 32'd2, 2'b10, 64'hBEEF, 1'b0, 48'd7, 64'h6000};

    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);            chk("rst_done", done, 1'b0);
    chk("rst_pulse", engine_start_pulse, 1'b0);
    chk("rst_loops", loops_done, 16'd0);    chk("rst_total", total_cycles, 48'd0);
    chk("rst_addr", source_address, 64'd0); chk("rst_serr", status_error, 2'b00);
    chk("rst_flags", {timeout_flag, abort_flag}, 2'b00);
    chk("rst_last", last_run_cycles, 32'd0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) begin
        dly_a[k] = tbl[i].d; err_a[k] = 2'b00; info_a[k] = 64'd0;
      end
      if (tbl[i].eloop > 0) begin
        err_a[tbl[i].eloop-1] = tbl[i].eval; info_a[tbl[i].eloop-1] = tbl[i].einfo;
      end
      p0 = pulse_cnt;
      run_job(tbl[i].num, tbl[i].len, tbl[i].size, tbl[i].loops, tbl[i].incr, tbl[i].addr, tbl[i].tmo);
      tick();
      chk($sformatf("v%0d_pulses", i), 64'(pulse_cnt - p0), 64'(tbl[i].x_pulses));
      for (int k = 0; k < n_pulses && k < tbl[i].x_pulses; k++)
        chk($sformatf("v%0d_addr%0d", i, k), pulse_addr[k], tbl[i].addr + tbl[i].x_step * 64'(k));
      if (tbl[i].x_pulses > 0) chk($sformatf("v%0d_lat", i), 64'(first_lat), 64'd0);
      chk($sformatf("v%0d_loops", i), loops_done, tbl[i].x_loops);
      chk($sformatf("v%0d_last", i), last_run_cycles, tbl[i].x_last);
      chk($sformatf("v%0d_serr", i), status_error, tbl[i].x_serr);
      chk($sformatf("v%0d_sinfo", i), status_error_info, tbl[i].x_sinfo);
      chk($sformatf("v%0d_tflag", i), timeout_flag, tbl[i].x_tflag);
      chk($sformatf("v%0d_total", i), total_cycles, tbl[i].x_total);
      chk($sformatf("v%0d_final", i), source_address, tbl[i].x_final);
      chk($sformatf("v%0d_done_busy", i), {done, busy}, 2'b10);
      if (tbl[i].num != 32'd0) begin
        chk($sformatf("v%0d_job", i), {rd_number, rd_pattern},
            {tbl[i].num, pat(tbl[i].len, tbl[i].size)});
        chk($sformatf("v%0d_pass", i), {rd_init_data, wrap_mode, wrap_len},
            {32'hC0DE_0000 ^ tbl[i].num, 1'b1, 4'd5});
      end
    end

    // Completion and abort in the same cycle: completion wins.
    setup_cfg(32'd1, 8'd0, 3'd0, 16'd1, 1'b0, 64'h7000, 32'd0);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("t5_pulse", engine_start_pulse, 1'b1);
    tick(); tick();
    rd_done_pulse = 1'b1; cfg_abort = 1'b1; tick(); rd_done_pulse = 1'b0; cfg_abort = 1'b0;
    chk("t5_loops", loops_done, 16'd1);  chk("t5_abort", abort_flag, 1'b0);
    chk("t5_done_busy", {done, busy}, 2'b10);  chk("t5_last", last_run_cycles, 32'd2);

    // Abort mid-run, with a start request while busy that must be ignored.
    setup_cfg(32'd3, 8'd0, 3'd0, 16'd3, 1'b0, 64'h7100, 32'd0);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("ab_pulse", engine_start_pulse, 1'b1);
    cfg_start = 1'b1; cfg_rd_number = 32'd99; tick(); cfg_start = 1'b0;
    tick();
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    chk("ab_flag", abort_flag, 1'b1);  chk("ab_done_busy", {done, busy}, 2'b10);
    chk("ab_number", rd_number, 32'd3); chk("ab_total", total_cycles, 48'd3);
    chk("ab_loops", loops_done, 16'd0);
    rd_done_pulse = 1'b1; rd_error = 2'b11; rd_error_info = 64'h1234; tick();
    rd_done_pulse = 1'b0; rd_error = 2'b00; rd_error_info = 64'd0;
    chk("idle_done_serr", status_error, 2'b00);  chk("idle_done_loops", loops_done, 16'd0);
    chk("idle_done_info", status_error_info, 64'd0);

    // Asynchronous reset mid-run, then a zero-burst start and a normal job.
    setup_cfg(32'd1, 8'd0, 3'd0, 16'd2, 1'b0, 64'h9000, 32'd0);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    repeat (4) tick();
    #2 resetn = 1'b0; #1;
    chk("t6_busy", busy, 1'b0);   chk("t6_pulse", engine_start_pulse, 1'b0);
    chk("t6_addr", source_address, 64'd0);  chk("t6_total", total_cycles, 48'd0);
    chk("t6_number", rd_number, 32'd0);     chk("t6_done", done, 1'b0);
    tick(); tick();
    resetn = 1'b1;
    p0 = pulse_cnt;
    setup_cfg(32'd0, 8'd0, 3'd0, 16'd1, 1'b0, 64'hA000, 32'd0);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("n0_done", done, 1'b1);  chk("n0_busy", busy, 1'b0);
    tick();
    chk("n0_nopulse", 64'(pulse_cnt - p0), 64'd0);  chk("n0_loops", loops_done, 16'd0);
    for (int k = 0; k < 16; k++) begin dly_a[k] = 6; err_a[k] = 2'b00; info_a[k] = 64'd0; end
    run_job(32'd1, 8'd0, 3'd0, 16'd1, 1'b0, 64'hB000, 32'd0);
    chk("t6_rerun_loops", loops_done, 16'd1);  chk("t6_rerun_last", last_run_cycles, 32'd6);
    chk("t6_rerun_total", total_cycles, 48'd7);

    // Random jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      r_num   = 32'($urandom_range(1, 8));
      r_len   = 8'($urandom);
      r_size  = 3'($urandom);
      r_loops = 16'($urandom_range(0, 4));
      r_incr  = 1'($urandom);
      r_addr  = {$urandom, $urandom};
      r_tmo   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(3, 12)) : 32'd0;
      for (int k = 0; k < 16; k++) begin
        dly_a[k]  = $urandom_range(1, 12);
        err_a[k]  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        info_a[k] = {$urandom, $urandom};
      end
      m  = model(r_num, r_len, r_size, r_loops, r_incr, r_addr, r_tmo);
      p0 = pulse_cnt;
      run_job(r_num, r_len, r_size, r_loops, r_incr, r_addr, r_tmo);
      tick();
      chk($sformatf("r%0d_pulses", j), 64'(pulse_cnt - p0), 64'(m.pulses));
      for (int k = 0; k < n_pulses && k < m.pulses; k++)
        chk($sformatf("r%0d_addr%0d", j, k), pulse_addr[k], exp_addr[k]);
      chk($sformatf("r%0d_loops", j), loops_done, m.loops);
      chk($sformatf("r%0d_last", j), last_run_cycles, m.last);
      chk($sformatf("r%0d_serr", j), {status_error, status_error_info}, {m.serr, m.sinfo});
      chk($sformatf("r%0d_flags", j), {timeout_flag, abort_flag}, {m.tflag, 1'b0});
      chk($sformatf("r%0d_total", j), total_cycles, m.total);
      chk($sformatf("r%0d_final", j), source_address, m.final_addr);
      chk($sformatf("r%0d_done_busy", j), {done, busy}, 2'b10);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
